// File: rtl/digit_recognizer_pkg.sv
// digit_recognizer_pkg: shared constants, state encoding and status-byte packing
package digit_recognizer_pkg;
    localparam int NUM_CLASSES = 10;
    localparam int NUM_PIXELS = 144;
    localparam int IMG_BYTES = 72;
    localparam logic [7:0] CMD_LOAD = 8'h00;
    localparam logic [7:0] CMD_READ = 8'hFF;
    localparam int ST_VALID = 7;
    localparam int ST_BUSY = 6;
    typedef enum logic [1:0] {IDLE, LOAD, COMPUTE} state_t;
    function automatic logic [7:0] status_byte(input logic valid, input logic busy, input logic [3:0] digit);
        status_byte = 8'h00;
        status_byte[ST_VALID] = valid;
        status_byte[ST_BUSY] = busy;
        status_byte[3:0] = digit;
    endfunction
endpackage

// File: rtl/spi_byte_slave.sv
// spi_byte_slave: synchronized SPI slave, LSB-first byte receive and status-byte transmit
module spi_byte_slave (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       sck,
    input  logic       ss,
    input  logic       mosi,
    input  logic [7:0] status,
    output logic       miso,
    output logic [7:0] rx_byte,
    output logic       rx_valid
);
    logic [2:0] sck_s;
    logic [2:0] ss_s;
    logic [1:0] mosi_s;
    logic [2:0] cnt;
    logic [7:0] tx;
    logic sck_rise, ss_fall;
    assign sck_rise = sck_s[1] & ~sck_s[2];
    assign ss_fall = ~ss_s[1] & ss_s[2];
    assign miso = ~ss_s[2] & tx[0];
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sck_s <= '0;
            ss_s <= '1;
            mosi_s <= '0;
            cnt <= '0;
            rx_byte <= '0;
            rx_valid <= 1'b0;
            tx <= '0;
        end else begin
            sck_s <= {sck_s[1:0], sck};
            ss_s <= {ss_s[1:0], ss};
            mosi_s <= {mosi_s[0], mosi};
            rx_valid <= 1'b0;
            if (ss_s[1])
                cnt <= '0;
            else if (sck_rise) begin
                cnt <= cnt + 3'd1;
                rx_byte <= {mosi_s[1], rx_byte[7:1]};
                rx_valid <= cnt == 3'd7;
            end
            if (ss_fall)
                tx <= status;
            else if (sck_rise && !ss_s[1])
                tx <= {1'b0, tx[7:1]};
        end
    end
endmodule

// File: rtl/digit_recognizer.sv
// digit_recognizer: SPI-loaded 12x12 image classifier with flash weights (optional DIGIT_RECOGNIZER_BIAS_EN)
module digit_recognizer
    import digit_recognizer_pkg::*;
#(
    parameter logic [15:0] WEIGHT_BASE = 16'h0000
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        SCK,
    input  logic        SS,
    input  logic        MOSI,
    output logic        MISO,
    inout  wire  [15:0] data,
    output logic [15:0] address,
    output logic        ce,
    output logic        oe,
    output logic        we
);
`ifdef DIGIT_RECOGNIZER_BIAS_EN
    localparam int BIAS = 1;
`else
    localparam int BIAS = 0;
`endif
    localparam int STEPS = NUM_PIXELS + BIAS;
    state_t state, nxt;
    logic [7:0] rx_byte, status, step, p_idx;
    logic rx_valid, valid, busy, rd_en;
    logic [3:0] pix [NUM_PIXELS];
    logic [6:0] byte_cnt;
    logic [3:0] digit, best_idx, cls, s2_pix, s2_cls;
    logic [10:0] w_off;
    logic [15:0] d_q;
    logic s2_valid, s2_start, s2_last, s2_bias;
    logic signed [31:0] acc, best, w_ext, prod, acc_new;
    logic cmd_load, enter_load, start, done, done_ok, win, is_bias, last_step;
    assign status = status_byte(valid, busy, digit);
    spi_byte_slave u_spi (
        .clk(clk),
        .n_rst(n_rst),
        .sck(SCK),
        .ss(SS),
        .mosi(MOSI),
        .status(status),
        .miso(MISO),
        .rx_byte(rx_byte),
        .rx_valid(rx_valid)
    );
    assign cmd_load = rx_valid && rx_byte == CMD_LOAD;
    assign enter_load = cmd_load && state != LOAD;
    assign start = state == LOAD && nxt == COMPUTE;
    assign done = s2_valid && s2_last && s2_cls == 4'(NUM_CLASSES - 1);
    assign done_ok = done && !enter_load;
    assign is_bias = BIAS != 0 && step == 8'd0;
    assign last_step = step == 8'(STEPS - 1);
    assign p_idx = is_bias ? 8'd0 : step - 8'(BIAS);
    assign w_ext = {{16{d_q[15]}}, d_q};
    assign prod = $signed({28'd0, s2_pix}) * w_ext;
    assign acc_new = (s2_start ? 32'sd0 : acc) + (s2_bias ? w_ext : prod);
    assign win = s2_cls == 4'd0 || acc_new > best;
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)
            state <= IDLE;
        else
            state <= nxt;
    end
    always_comb begin
        nxt = enter_load ? LOAD :
              (state == LOAD && rx_valid && byte_cnt == 7'(IMG_BYTES - 1)) ? COMPUTE :
              (state == COMPUTE && done) ? IDLE : state;
    end
    always_comb begin
        busy = state != IDLE;
        ce = ~rd_en;
        oe = ~rd_en;
        we = 1'b1;
        address = !rd_en ? 16'h0000 :
                  is_bias ? WEIGHT_BASE + 16'(NUM_CLASSES * NUM_PIXELS) + 16'(cls) :
                  WEIGHT_BASE + 16'(w_off);
    end
    always_ff @(posedge clk) begin
        if (state == LOAD && rx_valid) begin
            pix[{byte_cnt, 1'b0}] <= rx_byte[3:0];
            pix[{byte_cnt, 1'b1}] <= rx_byte[7:4];
        end
    end
    // Reads are issued one per cycle; the returned word is MACed one cycle later in the s2 stage.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            byte_cnt <= '0;
            rd_en <= 1'b0;
            cls <= '0;
            step <= '0;
            w_off <= '0;
            s2_valid <= 1'b0;
            s2_start <= 1'b0;
            s2_last <= 1'b0;
            s2_bias <= 1'b0;
            s2_pix <= '0;
            s2_cls <= '0;
            d_q <= '0;
            acc <= '0;
            best <= '0;
            best_idx <= '0;
            valid <= 1'b0;
            digit <= '0;
        end else begin
            byte_cnt <= enter_load ? 7'd0 : (state == LOAD && rx_valid) ? byte_cnt + 7'd1 : byte_cnt;
            if (enter_load)
                rd_en <= 1'b0;
            else if (start) begin
                rd_en <= 1'b1;
                cls <= '0;
                step <= '0;
                w_off <= '0;
            end else if (rd_en) begin
                step <= last_step ? 8'd0 : step + 8'd1;
                cls <= last_step ? cls + 4'd1 : cls;
                w_off <= is_bias ? w_off : w_off + 11'd1;
                rd_en <= !(last_step && cls == 4'(NUM_CLASSES - 1));
            end
            s2_valid <= rd_en && !enter_load;
            d_q <= data;
            s2_start <= step == 8'd0;
            s2_last <= last_step;
            s2_bias <= is_bias;
            s2_pix <= pix[p_idx];
            s2_cls <= cls;
            if (s2_valid)
                acc <= acc_new;
            if (s2_valid && s2_last && win) begin
                best <= acc_new;
                best_idx <= s2_cls;
            end
            valid <= enter_load ? 1'b0 : done_ok ? 1'b1 : valid;
            digit <= done_ok ? (win ? s2_cls : best_idx) : digit;
        end
    end
endmodule

// File: tb/tb_digit_recognizer.sv
// tb_digit_recognizer: randomized and directed checks of digit_recognizer against a score/argmax model
`timescale 1ns/1ps
module tb_digit_recognizer;
    import digit_recognizer_pkg::*;
    localparam logic [15:0] BASE = 16'h0200;
`ifdef DIGIT_RECOGNIZER_BIAS_EN
    localparam int NREADS = 1450;
`else
    localparam int NREADS = 1440;
`endif
    logic clk = 1'b0, n_rst = 1'b1, SCK = 1'b1, SS = 1'b1, MOSI = 1'b0;
    wire MISO, ce, oe, we;
    wire [15:0] data, address;
    logic [15:0] mem [0:65535];
    logic [7:0] img [0:IMG_BYTES-1];
    logic [7:0] rx;
    int total = 0, bad = 0;
    int run = 0, max_run = 0, last_run = 0;
    logic addr_bad = 1'b0, we_bad = 1'b0;

    always #2.5 clk = ~clk;
    assign data = (ce === 1'b0 && oe === 1'b0) ? mem[address] : 16'hzzzz;

    digit_recognizer #(.WEIGHT_BASE(BASE)) dut (
        .clk(clk), .n_rst(n_rst), .SCK(SCK), .SS(SS), .MOSI(MOSI), .MISO(MISO),
        .data(data), .address(address), .ce(ce), .oe(oe), .we(we)
    );

    always @(posedge clk) begin
        if (we !== 1'b1) we_bad <= 1'b1;
        if (ce === 1'b0) begin
            run <= run + 1;
            if (address < BASE || 32'(address) >= 32'(BASE) + NREADS) addr_bad <= 1'b1;
        end else if (run != 0) begin
            last_run <= run;
            if (run > max_run) max_run <= run;
            run <= 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] r);
        SS = 1'b0;
        #25;
        for (int i = 0; i < 8; i++) begin
            SCK = 1'b0;
            r[i] = MISO;
            MOSI = tx[i];
            #25;
            SCK = 1'b1;
            #25;
        end
        SS = 1'b1;
        #25;
    endtask

    task automatic partial(input int n);
        SS = 1'b0;
        #25;
        for (int i = 0; i < n; i++) begin
            SCK = 1'b0;
            MOSI = 1'($urandom);
            #25;
            SCK = 1'b1;
            #25;
        end
        SS = 1'b1;
        #25;
    endtask

    task automatic read_status(input string tag, input logic [7:0] exp);
        logic [7:0] r;
        xfer(CMD_READ, r);
        check(tag, 32'(r), 32'(exp));
        check("digit_range", 32'(r[3:0] <= 4'd9), 32'd1);
    endtask

    task automatic send_image(input int cut, input logic chk, input logic [7:0] exp);
        logic [7:0] r;
        xfer(CMD_LOAD, r);
        if (chk) check("cmd_status", 32'(r), 32'(exp));
        for (int k = 0; k < IMG_BYTES; k++) begin
            if (k == cut) partial(5);
            xfer(img[k], r);
            if (chk) check("load_status", 32'(r), 32'(exp));
        end
    endtask

    task automatic fill_w(input int mode);
        for (int c = 0; c < NUM_CLASSES; c++) begin
            for (int p = 0; p < NUM_PIXELS; p++)
                mem[32'(BASE) + c * NUM_PIXELS + p] = mode == 0 ? 16'h0000 : mode == 1 ? 16'(c == 3) :
                                                      mode == 2 ? 16'(-c) : 16'($urandom);
            mem[32'(BASE) + NUM_CLASSES * NUM_PIXELS + c] = mode == 3 ? 16'($urandom_range(0, 4000)) - 16'd2000 : 16'h0000;
        end
    endtask

    task automatic fill_img(input int mode);
        for (int k = 0; k < IMG_BYTES; k++)
            img[k] = mode == 0 ? 8'h00 : mode == 1 ? 8'h11 : mode == 2 ? 8'hFF : 8'($urandom);
    endtask

    function automatic logic [7:0] model();
        int best, bi, s, px;
        logic [7:0] b;
        best = 0;
        bi = 0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            s = 0;
`ifdef DIGIT_RECOGNIZER_BIAS_EN
            s = int'($signed(mem[32'(BASE) + NUM_CLASSES * NUM_PIXELS + c]));
`endif
            for (int p = 0; p < NUM_PIXELS; p++) begin
                b = img[p / 2];
                px = (p % 2 == 1) ? int'(b[7:4]) : int'(b[3:0]);
                s += px * int'($signed(mem[32'(BASE) + c * NUM_PIXELS + p]));
            end
            if (c == 0 || s > best) begin
                best = s;
                bi = c;
            end
        end
        return {4'b1000, 4'(bi)};
    endfunction

    initial begin
        logic [7:0] exp_b;
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        fill_w(0);
        fill_img(0);
        #5 n_rst = 1'b0;
        #20;
        check("rst_miso", 32'(MISO), 32'd0);
        check("rst_ce", 32'(ce), 32'd1);
        check("rst_oe", 32'(oe), 32'd1);
        check("rst_we", 32'(we), 32'd1);
        check("rst_addr", 32'(address), 32'd0);
        n_rst = 1'b1;
        #50;
        read_status("rst_status", 8'h00);

        fill_w(1);
        fill_img(2);
        send_image(-1, 1'b0, 8'h00);
        #7500;
        check("class3_model", 32'(model()), 32'h83);
        read_status("class3", model());
        check("read_count", 32'(last_run), 32'(NREADS));

        fill_w(0);
        fill_img(3);
        send_image(-1, 1'b0, 8'h00);
        #7500;
        read_status("zero_w", model());

        fill_w(2);
        fill_img(1);
        send_image(-1, 1'b0, 8'h00);
        #7500;
        read_status("neg_w_ones", model());
        fill_img(0);
        send_image(-1, 1'b0, 8'h00);
        #7500;
        read_status("neg_w_zeros", model());

        fill_w(3);
        fill_img(3);
        send_image(-1, 1'b0, 8'h00);
        read_status("busy", 8'h40);
        #2000;
        check("ce_compute", 32'(ce), 32'd0);
        fill_img(3);
        send_image(30, 1'b1, 8'h40);
        #7500;
        exp_b = model();
        read_status("abort_result", exp_b);
        read_status("result_hold", exp_b);

        xfer(CMD_LOAD, rx);
        for (int k = 0; k < 10; k++) xfer(8'($urandom), rx);
        SS = 1'b0;
        #30;
        n_rst = 1'b0;
        #1;
        check("rstload_miso", 32'(MISO), 32'd0);
        check("rstload_ce", 32'(ce), 32'd1);
        check("rstload_oe", 32'(oe), 32'd1);
        check("rstload_we", 32'(we), 32'd1);
        #9;
        SS = 1'b1;
        n_rst = 1'b1;
        #50;
        read_status("rstload_status", 8'h00);

        fill_img(3);
        send_image(-1, 1'b0, 8'h00);
        #2000;
        check("ce_before_rst", 32'(ce), 32'd0);
        n_rst = 1'b0;
        #1;
        check("rstcomp_ce", 32'(ce), 32'd1);
        check("rstcomp_oe", 32'(oe), 32'd1);
        check("rstcomp_addr", 32'(address), 32'd0);
        check("rstcomp_miso", 32'(MISO), 32'd0);
        #4;
        n_rst = 1'b1;
        #50;
        read_status("rstcomp_status", 8'h00);

        check("addr_range", 32'(addr_bad), 32'd0);
        check("we_tied", 32'(we_bad), 32'd0);
        check("max_reads", 32'(max_run <= NREADS), 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
